spi_ram_param: RTL and testbench

Parametrised single-port RAM slave for the SPI interface: it takes framed command/payload words from the SPI slave front end and performs address-load, write, and read operations. Successor to the fixed 256x8 SPI RAM, adding:
- configurable data width, address width, and depth;
- optional address auto-increment for burst transfers;
- an out-of-range address error pulse.

Sits between the SPI slave shift logic (`din`/`rx_valid`) and the MISO serialiser (`dout`/`tx_valid`).

---
 rtl/spi_ram_param_if.sv | 21 ++
 rtl/spi_ram_param.sv | 103 ++++++++++
 tb/tb_spi_ram_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_param_if.sv
// Command/response bundle between the SPI slave front end and the parametrised RAM.
// The master drives framed command words; the slave returns read data and the error pulse.
interface spi_ram_param_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              rx_valid;
  logic [DATA_W+1:0] din;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              err;

  modport master (
    output rx_valid, din,
    input  dout, tx_valid, err
  );

  modport slave (
    input  rx_valid, din,
    output dout, tx_valid, err
  );
endinterface

// File: rtl/spi_ram_param.sv
// Parametrised single-port RAM behind the SPI slave: address-load, write and read commands.
// It has optional address auto-increment and flags address loads outside DEPTH.
module spi_ram_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter bit          AUTO_INC = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_param_if.slave bus
);
  localparam int unsigned       IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    OpWrAddr = 2'b00,
    OpWrData = 2'b01,
    OpRdAddr = 2'b10,
    OpRdData = 2'b11
  } op_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;
  logic              mem_we;

  op_e               op;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_in;
  logic              addr_oor;

  assign op       = op_e'(bus.din[DATA_W+1:DATA_W]);
  assign payload  = bus.din[DATA_W-1:0];
  assign addr_in  = payload[ADDR_W-1:0];
  assign addr_oor = {1'b0, addr_in} >= DepthW;

  // Post-increment wraps at DEPTH-1, so auto-increment can never leave the valid range.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LastAddr) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = '0;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    if (bus.rx_valid) begin
      unique case (op)
        OpWrAddr: begin
          if (addr_oor) err_d = 1'b1;
          else          wr_addr_d = addr_in;
        end
        OpWrData: begin
          mem_we = 1'b1;
          if (AUTO_INC) wr_addr_d = next_addr(wr_addr_q);
        end
        OpRdAddr: begin
          if (addr_oor) err_d = 1'b1;
          else          rd_addr_d = addr_in;
        end
        OpRdData: begin
          dout_d     = mem_q[rd_addr_q[IdxW-1:0]];
          tx_valid_d = 1'b1;
          if (AUTO_INC) rd_addr_d = next_addr(rd_addr_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr_q[IdxW-1:0]] <= payload;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_ram_param.sv
// Bench for spi_ram_param: three configurations checked against an array-based command model.
module tb_spi_ram_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [18:0] CWA = 19'h40000;
  localparam logic [18:0] CWD = 19'h50000;
  localparam logic [18:0] CRA = 19'h60000;
  localparam logic [18:0] CRD = 19'h70000;
  localparam logic [18:0] CIDLE_RD = 19'h30000;

  spi_ram_param_if #(.DATA_W(8))  bus_a ();
  spi_ram_param_if #(.DATA_W(8))  bus_b ();
  spi_ram_param_if #(.DATA_W(16)) bus_c ();

  spi_ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .AUTO_INC(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  spi_ram_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .AUTO_INC(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  spi_ram_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .AUTO_INC(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  int pass_cnt = 0;
  int total_cnt = 0;

  int dw [3] = '{8, 8, 16};
  int aw [3] = '{8, 4, 10};
  int dp [3] = '{200, 16, 1024};
  int ai [3] = '{0, 1, 0};

  logic [15:0] m_mem [3][1024];
  bit          m_ok  [3][1024];
  int          m_wr  [3];
  int          m_rd  [3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_wr[k] = 0;
      m_rd[k] = 0;
    end
  endfunction

  // One accepted command: returns what the next cycle must show.
  function automatic void model(input int k, input bit v, input logic [1:0] op,
                                input logic [15:0] pl_raw, output logic [15:0] ed,
                                output logic etv, output logic ee, output bit ek);
    int pl;
    int a;
    pl  = int'(pl_raw) & ((1 << dw[k]) - 1);
    a   = pl % (1 << aw[k]);
    ed  = '0;
    etv = 1'b0;
    ee  = 1'b0;
    ek  = 1'b1;
    if (!v) return;
    case (op)
      2'd0: if (a >= dp[k]) ee = 1'b1; else m_wr[k] = a;
      2'd1: begin
        m_mem[k][m_wr[k]] = 16'(pl);
        m_ok[k][m_wr[k]]  = 1'b1;
        if (ai[k] != 0) m_wr[k] = (m_wr[k] + 1) % dp[k];
      end
      2'd2: if (a >= dp[k]) ee = 1'b1; else m_rd[k] = a;
      default: begin
        etv = 1'b1;
        ek  = m_ok[k][m_rd[k]];
        ed  = m_mem[k][m_rd[k]];
        if (ai[k] != 0) m_rd[k] = (m_rd[k] + 1) % dp[k];
      end
    endcase
  endfunction

  task automatic drive(input int k, input bit v, input logic [1:0] op, input logic [15:0] pl);
    case (k)
      0: begin bus_a.rx_valid = v; bus_a.din = {op, pl[7:0]}; end
      1: begin bus_b.rx_valid = v; bus_b.din = {op, pl[7:0]}; end
      default: begin bus_c.rx_valid = v; bus_c.din = {op, pl}; end
    endcase
  endtask

  task automatic sample(input int k, output logic [15:0] gd, output logic gtv, output logic ge);
    case (k)
      0: begin gd = {8'h00, bus_a.dout}; gtv = bus_a.tx_valid; ge = bus_a.err; end
      1: begin gd = {8'h00, bus_b.dout}; gtv = bus_b.tx_valid; ge = bus_b.err; end
      default: begin gd = bus_c.dout; gtv = bus_c.tx_valid; ge = bus_c.err; end
    endcase
  endtask

  task automatic step(input int k, input bit v, input logic [1:0] op, input logic [15:0] pl,
                      output logic [15:0] gd, output logic gtv, output logic ge);
    drive(k, v, op, pl);
    @(posedge clk);
    #1;
    sample(k, gd, gtv, ge);
    drive(k, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic test_reset();
    logic [18:0] pre [4] = '{CWA | 19'h00, CWD | 19'h5A, CRA | 19'h12, CRD};
    logic [15:0] ed, gd;
    logic etv, ee, gtv, ge;
    bit ek;
    drive(0, 1'b0, 2'd0, 16'h0);
    drive(1, 1'b0, 2'd0, 16'h0);
    drive(2, 1'b0, 2'd0, 16'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sample(k, gd, gtv, ge);
      total_cnt++;
      if (gd !== 16'h0 || gtv !== 1'b0 || ge !== 1'b0)
        $display("FAIL reset_state[%0d] got dout=%h tv=%b err=%b want 0/0/0", k, gd, gtv, ge);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    foreach (pre[i]) begin
      model(0, pre[i][18], pre[i][17:16], pre[i][15:0], ed, etv, ee, ek);
      step(0, pre[i][18], pre[i][17:16], pre[i][15:0], gd, gtv, ge);
      total_cnt++;
      if (gtv !== etv || ge !== ee || (ek && gd !== ed))
        $display("FAIL reset_pre[%0d] got tv=%b err=%b dout=%h want tv=%b err=%b dout=%h",
                 i, gtv, ge, gd, etv, ee, ed);
      else pass_cnt++;
    end
    // Read in flight, then reset lands mid-cycle with the read-data still presented.
    drive(0, 1'b1, 2'd3, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sample(0, gd, gtv, ge);
    total_cnt++;
    if (gd !== 16'h0 || gtv !== 1'b0 || ge !== 1'b0)
      $display("FAIL reset_async got dout=%h tv=%b err=%b want 0/0/0", gd, gtv, ge);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1'b0, 2'd0, 16'h0);
    model_reset();
    #1;
    sample(0, gd, gtv, ge);
    total_cnt++;
    if (gtv !== 1'b0 || gd !== 16'h0)
      $display("FAIL reset_release got tv=%b dout=%h want tv=0 dout=0", gtv, gd);
    else pass_cnt++;
    model(0, 1'b1, 2'd3, 16'h0, ed, etv, ee, ek);
    step(0, 1'b1, 2'd3, 16'h0, gd, gtv, ge);
    total_cnt++;
    if (gtv !== 1'b1 || gd !== 16'h5A || gd !== ed)
      $display("FAIL reset_read_addr0 got tv=%b dout=%h want tv=1 dout=5a", gtv, gd);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [18:0] seq [6] = '{CWA | 19'h12, CWD | 19'hA5, CRA | 19'h12, CRD, 19'h0, CRD};
    logic [15:0] ed, gd;
    logic etv, ee, gtv, ge;
    bit ek;
    foreach (seq[i]) begin
      model(0, seq[i][18], seq[i][17:16], seq[i][15:0], ed, etv, ee, ek);
      step(0, seq[i][18], seq[i][17:16], seq[i][15:0], gd, gtv, ge);
      total_cnt++;
      if (gtv !== etv || ge !== ee || (ek && gd !== ed))
        $display("FAIL basic[%0d] got tv=%b err=%b dout=%h want tv=%b err=%b dout=%h",
                 i, gtv, ge, gd, etv, ee, ed);
      else pass_cnt++;
    end
  endtask

  task automatic test_out_of_range();
    logic [18:0] seq [8] = '{CWA | 19'h05, CWA | 19'hC8, 19'h0, CWD | 19'h77,
                             CRA | 19'h05, CRA | 19'hFF, CRD, CRA | 19'hC7};
    logic [15:0] ed, gd;
    logic etv, ee, gtv, ge;
    bit ek;
    foreach (seq[i]) begin
      model(0, seq[i][18], seq[i][17:16], seq[i][15:0], ed, etv, ee, ek);
      step(0, seq[i][18], seq[i][17:16], seq[i][15:0], gd, gtv, ge);
      total_cnt++;
      if (gtv !== etv || ge !== ee || (ek && gd !== ed))
        $display("FAIL oor[%0d] got tv=%b err=%b dout=%h want tv=%b err=%b dout=%h",
                 i, gtv, ge, gd, etv, ee, ed);
      else pass_cnt++;
    end
  endtask

  task automatic test_auto_inc_wrap();
    logic [18:0] seq [9] = '{CWA | 19'h0E, CWD | 19'h11, CWD | 19'h22, CWD | 19'h33,
                             CRA | 19'h0E, CRD, CRD, CRD, 19'h0};
    logic [15:0] ed, gd;
    logic etv, ee, gtv, ge;
    bit ek;
    foreach (seq[i]) begin
      model(1, seq[i][18], seq[i][17:16], seq[i][15:0], ed, etv, ee, ek);
      step(1, seq[i][18], seq[i][17:16], seq[i][15:0], gd, gtv, ge);
      total_cnt++;
      if (gtv !== etv || ge !== ee || (ek && gd !== ed))
        $display("FAIL autoinc[%0d] got tv=%b err=%b dout=%h want tv=%b err=%b dout=%h",
                 i, gtv, ge, gd, etv, ee, ed);
      else pass_cnt++;
    end
  endtask

  task automatic test_non_read();
    logic [18:0] seq [5] = '{CWA | 19'h10, CWD | 19'h3C, CRA | 19'h10, CIDLE_RD, CIDLE_RD | 19'hFF};
    logic [15:0] ed, gd;
    logic etv, ee, gtv, ge;
    bit ek;
    foreach (seq[i]) begin
      model(0, seq[i][18], seq[i][17:16], seq[i][15:0], ed, etv, ee, ek);
      step(0, seq[i][18], seq[i][17:16], seq[i][15:0], gd, gtv, ge);
      total_cnt++;
      if (gtv !== 1'b0 || gd !== 16'h0 || ge !== ee)
        $display("FAIL nonread[%0d] got tv=%b dout=%h err=%b want tv=0 dout=0 err=%b",
                 i, gtv, gd, ge, ee);
      else pass_cnt++;
    end
  endtask

  task automatic test_wide();
    logic [18:0] seq [9] = '{CWA | 19'h3FF, CWD | 19'hBEEF, CRA | 19'h3FF, CRD,
                             CWD | 19'h1234, CRD, CWA | 19'hFC05, CWD | 19'h0F0F, CRD};
    logic [15:0] ed, gd;
    logic etv, ee, gtv, ge;
    bit ek;
    foreach (seq[i]) begin
      model(2, seq[i][18], seq[i][17:16], seq[i][15:0], ed, etv, ee, ek);
      step(2, seq[i][18], seq[i][17:16], seq[i][15:0], gd, gtv, ge);
      total_cnt++;
      if (gtv !== etv || ge !== ee || (ek && gd !== ed))
        $display("FAIL wide[%0d] got tv=%b err=%b dout=%h want tv=%b err=%b dout=%h",
                 i, gtv, ge, gd, etv, ee, ed);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [15:0] ed, gd, pl;
    logic etv, ee, gtv, ge;
    logic [1:0] op;
    bit ek, v;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 150; n++) begin
        v  = ($urandom_range(0, 9) != 0);
        op = 2'($urandom_range(0, 3));
        pl = 16'($urandom);
        // Mostly keep addresses low so reads tend to hit written words.
        if (!op[0] && $urandom_range(0, 3) != 0)
          pl = pl & ~16'(((1 << aw[k]) - 1) & ~32'hF);
        model(k, v, op, pl, ed, etv, ee, ek);
        step(k, v, op, pl, gd, gtv, ge);
        total_cnt++;
        if (gtv !== etv || ge !== ee || (ek && gd !== ed))
          $display("FAIL random[%0d.%0d] got tv=%b err=%b dout=%h want tv=%b err=%b dout=%h",
                   k, n, gtv, ge, gd, etv, ee, ed);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_range();
    test_auto_inc_wrap();
    test_non_read();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
